regfile_wp_arbiter: RTL and testbench

REGFILE_WP_ARBITER -- requirements
Module: regfile_wp_arbiter

---
 rtl/regfile_wp_arbiter.sv | 142 ++++++++++++++
 tb/tb_regfile_wp_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wp_arbiter.sv
// Purpose  : arbitrates ALU and load writebacks onto the single register-file write port.
// Latency  : a request accepted on edge N drives we3/wa3/wd3 in the cycle after edge N, unless rf_stall holds it.
// Backpress: one-entry hold register; readys drop while the entry is held and rf_stall is high.
//
// Ports
//   clk, rst_n                 sole clock (rising edge) and synchronous active-low reset
//   alu_valid/alu_wa/alu_wd    ALU writeback request; alu_ready marks acceptance
//   mem_valid/mem_wa/mem_wd    load writeback request;  mem_ready marks acceptance
//   rf_stall                   write port unavailable this cycle
//   we3/wa3/wd3                register-file write-port drive
//   pending[14:0]              one-hot of the register whose write is held, not yet committed
//   err_r15                    one-cycle pulse when a held write to r15 is dropped
//
// Build option: define REGFILE_WP_RR_EN for round-robin arbitration on contention;
// left undefined, the load path has fixed priority over the ALU path.

module regfile_wp_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_valid,
  input  logic [3:0]  alu_wa,
  input  logic [31:0] alu_wd,
  output logic        alu_ready,
  input  logic        mem_valid,
  input  logic [3:0]  mem_wa,
  input  logic [31:0] mem_wd,
  output logic        mem_ready,
  input  logic        rf_stall,
  output logic        we3,
  output logic [3:0]  wa3,
  output logic [31:0] wd3,
  output logic [14:0] pending,
  output logic        err_r15
);

  // Held write: destination register and data.
  typedef struct packed {
    logic [3:0]  wa;
    logic [31:0] wd;
  } wr_req_t;

  localparam logic [3:0] R15 = 4'hF;

  logic    hold_v_q, hold_v_d;
  wr_req_t hold_q, hold_d;

  logic draining;
  logic can_acc;
  logic pick_mem;
  logic pick_alu;
  logic accept;
  logic hold_is_r15;

  // The entry leaves the hold register in any cycle the port is free, whether
  // it is actually written (normal register) or dropped (r15).
  assign draining    = hold_v_q & ~rf_stall;
  assign can_acc     = ~hold_v_q | draining;
  assign hold_is_r15 = (hold_q.wa == R15);

  // ---------------------------------------------------------------------------
  // Arbitration. pick_* says who would win if acceptance were possible; the
  // readys then qualify that with can_acc and reset.
  // ---------------------------------------------------------------------------
`ifdef REGFILE_WP_RR_EN
  // Last-grant flag: 1 = load path was granted most recently, 0 = ALU.
  logic last_mem_q, last_mem_d;

  // On contention the side not granted last wins; a lone requester always wins.
  assign pick_mem = mem_valid & (~alu_valid | ~last_mem_q);

  always_comb begin
    last_mem_d = last_mem_q;
    if (accept) begin
      last_mem_d = mem_ready;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_mem_q <= 1'b0;
    end else begin
      last_mem_q <= last_mem_d;
    end
  end
`else
  // Fixed priority: loads win over ALU results whenever both are present.
  assign pick_mem = mem_valid;
`endif

  assign pick_alu = alu_valid & ~pick_mem;

  // Readys are forced low while reset is asserted so nothing is seen as
  // accepted during a cycle whose edge is going to clear the hold register.
  assign mem_ready = rst_n & can_acc & pick_mem;
  assign alu_ready = rst_n & can_acc & pick_alu;
  assign accept    = mem_ready | alu_ready;

  // ---------------------------------------------------------------------------
  // Hold register next state. A new acceptance overwrites a draining entry in
  // the same edge, which is what sustains one write per cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    hold_v_d = hold_v_q;
    hold_d   = hold_q;
    if (mem_ready) begin
      hold_v_d = 1'b1;
      hold_d   = '{wa: mem_wa, wd: mem_wd};
    end else if (alu_ready) begin
      hold_v_d = 1'b1;
      hold_d   = '{wa: alu_wa, wd: alu_wd};
    end else if (draining) begin
      hold_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_v_q <= 1'b0;
      hold_q   <= '0;
    end else begin
      hold_v_q <= hold_v_d;
      hold_q   <= hold_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Write-port drive and status. All outputs are gated by rst_n so that a
  // held entry is never committed in the cycle reset is asserted.
  // ---------------------------------------------------------------------------
  assign we3     = rst_n & draining & ~hold_is_r15;
  assign err_r15 = rst_n & draining &  hold_is_r15;
  assign wa3     = hold_q.wa;
  assign wd3     = hold_q.wd;

  always_comb begin
    pending = '0;
    if (rst_n && hold_v_q && !hold_is_r15) begin
      pending = 15'd1 << hold_q.wa;
    end
  end

endmodule

// File: tb/tb_regfile_wp_arbiter.sv
module tb_regfile_wp_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid;
  logic [3:0]  alu_wa;
  logic [31:0] alu_wd;
  logic        alu_ready;
  logic        mem_valid;
  logic [3:0]  mem_wa;
  logic [31:0] mem_wd;
  logic        mem_ready;
  logic        rf_stall;
  logic        we3;
  logic [3:0]  wa3;
  logic [31:0] wd3;
  logic [14:0] pending;
  logic        err_r15;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [3:0]  wa;
    logic [31:0] wd;
    logic        r15;
  } exp_t;

  exp_t sb[$];
  logic exp_m [4];

  always #5 clk = ~clk;

  regfile_wp_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .alu_valid (alu_valid),
    .alu_wa    (alu_wa),
    .alu_wd    (alu_wd),
    .alu_ready (alu_ready),
    .mem_valid (mem_valid),
    .mem_wa    (mem_wa),
    .mem_wd    (mem_wd),
    .mem_ready (mem_ready),
    .rf_stall  (rf_stall),
    .we3       (we3),
    .wa3       (wa3),
    .wd3       (wd3),
    .pending   (pending),
    .err_r15   (err_r15)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [3:0] wa, input logic [31:0] wd);
    exp_t e;
    e.wa  = wa;
    e.wd  = wd;
    e.r15 = (wa == 4'hF);
    sb.push_back(e);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Sample readys at the negedge and record the expected commit for whichever
  // side the bench expects to be accepted.
  task automatic step_chk(input string tag, input logic exp_alu, input logic exp_mem);
    @(negedge clk);
    check({tag, "_alu_ready"}, 32'(alu_ready), 32'(exp_alu));
    check({tag, "_mem_ready"}, 32'(mem_ready), 32'(exp_mem));
    if (exp_mem) push(mem_wa, mem_wd);
    if (exp_alu) push(alu_wa, alu_wd);
  endtask

  // Commit monitor: every write or r15 drop must match the oldest expectation.
  always @(negedge clk) begin
    if (we3 === 1'b1 || err_r15 === 1'b1) begin
      checks++;
      assert (sb.size() > 0) else begin
        errors++;
        $error("FAIL sb_unexpected_commit: observed we3=%0b err_r15=%0b wa3=%0d expected no commit",
               we3, err_r15, wa3);
      end
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        check("commit_wa3", 32'(wa3), 32'(e.wa));
        check("commit_we3", 32'(we3), 32'(!e.r15));
        check("commit_err_r15", 32'(err_r15), 32'(e.r15));
        if (!e.r15) check("commit_wd3", wd3, e.wd);
      end
    end
  end

  initial begin
`ifdef REGFILE_WP_RR_EN
    exp_m[0] = 1'b1; exp_m[1] = 1'b0; exp_m[2] = 1'b1; exp_m[3] = 1'b0;
`else
    exp_m[0] = 1'b1; exp_m[1] = 1'b1; exp_m[2] = 1'b1; exp_m[3] = 1'b1;
`endif

    // Reset with both requesters valid: nothing may be accepted or driven.
    rst_n = 1'b0; rf_stall = 1'b0;
    alu_valid = 1'b1; alu_wa = 4'd4; alu_wd = 32'h1;
    mem_valid = 1'b1; mem_wa = 4'd6; mem_wd = 32'h2;
    @(negedge clk);
    check("rst_we3", 32'(we3), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_alu_ready", 32'(alu_ready), 32'd0);
    check("rst_mem_ready", 32'(mem_ready), 32'd0);
    check("rst_err_r15", 32'(err_r15), 32'd0);
    nxt();
    rst_n = 1'b1; alu_valid = 1'b0; mem_valid = 1'b0;
    @(negedge clk);
    check("idle_we3", 32'(we3), 32'd0);
    check("idle_pending", 32'(pending), 32'd0);

    // Single ALU write: accepted same cycle, committed the next.
    nxt();
    alu_valid = 1'b1; alu_wa = 4'd3; alu_wd = 32'hDEADBEEF;
    step_chk("single", 1'b1, 1'b0);
    nxt();
    alu_valid = 1'b0;
    @(negedge clk);
    check("single_we3", 32'(we3), 32'd1);
    check("single_pending", 32'(pending), 32'h0008);

    // Contention straight after reset.
    nxt(); rst_n = 1'b0;
    nxt(); rst_n = 1'b1;
    alu_valid = 1'b1; alu_wa = 4'd1; alu_wd = 32'h11;
    mem_valid = 1'b1; mem_wa = 4'd2; mem_wd = 32'h22;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) nxt();
      step_chk($sformatf("contend%0d", i), !exp_m[i], exp_m[i]);
      if (i > 0) check($sformatf("contend%0d_we3", i), 32'(we3), 32'd1);
    end
    nxt();
    alu_valid = 1'b0; mem_valid = 1'b0;
    @(negedge clk);
    check("contend_tail_we3", 32'(we3), 32'd1);
    nxt();
    @(negedge clk);
    check("contend_idle_we3", 32'(we3), 32'd0);

    // Stall: held load to r5, queued ALU request waits three cycles.
    nxt();
    mem_valid = 1'b1; mem_wa = 4'd5; mem_wd = 32'h55;
    step_chk("stall_acc", 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      nxt();
      mem_valid = 1'b0; rf_stall = 1'b1;
      alu_valid = 1'b1; alu_wa = 4'd9; alu_wd = 32'h99;
      step_chk($sformatf("stall%0d", i), 1'b0, 1'b0);
      check($sformatf("stall%0d_we3", i), 32'(we3), 32'd0);
      check($sformatf("stall%0d_pending", i), 32'(pending), 32'h0020);
    end
    nxt();
    rf_stall = 1'b0;
    step_chk("stall_release", 1'b1, 1'b0);
    check("stall_release_we3", 32'(we3), 32'd1);
    nxt();
    alu_valid = 1'b0;
    @(negedge clk);
    check("stall_next_pending", 32'(pending), 32'h0200);

    // Write to r15: accepted, then dropped with an error pulse.
    nxt();
    mem_valid = 1'b1; mem_wa = 4'hF; mem_wd = 32'h100;
    step_chk("r15_acc", 1'b0, 1'b1);
    nxt();
    mem_valid = 1'b0;
    @(negedge clk);
    check("r15_we3", 32'(we3), 32'd0);
    check("r15_err", 32'(err_r15), 32'd1);
    check("r15_pending", 32'(pending), 32'd0);
    nxt();
    @(negedge clk);
    check("r15_err_pulse_end", 32'(err_r15), 32'd0);

    // Reset before a held r7 write drains: the write must never appear.
    nxt();
    alu_valid = 1'b1; alu_wa = 4'd7; alu_wd = 32'h77;
    step_chk("rstmid_acc", 1'b1, 1'b0);
    nxt();
    alu_valid = 1'b0; rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    check("rstmid_we3", 32'(we3), 32'd0);
    check("rstmid_pending", 32'(pending), 32'd0);
    for (int i = 0; i < 2; i++) begin
      nxt();
      rst_n = 1'b1;
      @(negedge clk);
      check($sformatf("rstmid_after%0d_we3", i), 32'(we3), 32'd0);
      check($sformatf("rstmid_after%0d_pending", i), 32'(pending), 32'd0);
    end

    nxt();
    @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
